// File: rtl/interp_pkg.sv
// Shared types and constants for the interpolator line sequencer: line geometry,
// per-line cycle phase boundaries, pass mode encoding and the sequencer state enum.
package interp_pkg;

    localparam int LINE_LEN = 16;
    localparam int PRE_FILL = 8;
    localparam int TAIL     = 5;
    localparam int RD_LAT   = 1;

    localparam int LINE_CYCLES = PRE_FILL + LINE_LEN + TAIL + RD_LAT;
    localparam int CNT_W       = $clog2(LINE_CYCLES);
    localparam int LINE_W      = $clog2(LINE_LEN);

    typedef logic [CNT_W-1:0]  cycleT;
    typedef logic [LINE_W-1:0] lineT;

    // Phase boundaries within one line, expressed in the counter's own width.
    localparam cycleT STREAM_FIRST = cycleT'(PRE_FILL);
    localparam cycleT TAIL_FIRST   = cycleT'(PRE_FILL + LINE_LEN);
    localparam cycleT DRAIN_FIRST  = cycleT'(PRE_FILL + LINE_LEN + TAIL);
    localparam cycleT T_LAST       = cycleT'(LINE_CYCLES - 1);
    localparam cycleT CAP_FIRST    = cycleT'(PRE_FILL + 5 + RD_LAT);
    localparam cycleT CAP_LAST     = cycleT'(PRE_FILL + 20 + RD_LAT);
    localparam lineT  LINE_LAST    = lineT'(LINE_LEN - 1);

    localparam logic MODE_ROW = 1'b0;
    localparam logic MODE_COL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM,
        ST_TAIL,
        ST_DRAIN
    } seqState;

    // The active phase of a line is a pure function of the cycle counter.
    function automatic seqState phaseOf(input cycleT t);
        if (t < STREAM_FIRST)     return ST_FILL;
        else if (t < TAIL_FIRST)  return ST_STREAM;
        else if (t < DRAIN_FIRST) return ST_TAIL;
        else                      return ST_DRAIN;
    endfunction

endpackage

// File: rtl/interp_addr_gen.sv
// Stride/offset calculator: row mode walks base + line*LINE_LEN + pos, column mode
// walks base + line + pos*LINE_LEN, both wrapping modulo 2^W.
module interp_addr_gen
    import interp_pkg::*;
#(
    parameter int W = 32
) (
    input  logic              mode,
    input  logic [W-1:0]      base,
    input  logic [LINE_W-1:0] line,
    input  logic [LINE_W-1:0] pos,
    output logic [W-1:0]      addr
);

    logic [W-1:0] lineW;
    logic [W-1:0] posW;

    always_comb begin
        lineW = W'(line);
        posW  = W'(pos);
        if (mode == MODE_COL) begin
            addr = base + lineW + posW * W'(LINE_LEN);
        end else begin
            addr = base + lineW * W'(LINE_LEN) + posW;
        end
    end

endmodule

// File: rtl/interp_line_sequencer.sv
// Drives the 8-tap interpolator over a 16x16 tile one edge-padded line at a time.
// Optional pass statistics ports are enabled with the INTERP_SEQ_PERF_EN macro.
module interp_line_sequencer
    import interp_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_base,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              cap_valid,
    output logic [IDX_W-1:0]  cap_idx,
    output logic [IDX_W-1:0]  line_idx
`ifdef INTERP_SEQ_PERF_EN
    ,
    output logic [31:0]       pass_cycles,
    output logic [15:0]       pass_count
`endif
);

    seqState           state, stateNext;
    cycleT             t, tNext;
    lineT              line, lineNext;
    logic              modeQ, modeNext;
    logic [ADDR_W-1:0] baseQ, baseNext;
    logic              doneNext;

    logic              rdEnNext;
    logic              capNext;
    lineT              kNext;
    lineT              rNext;
    logic [ADDR_W-1:0] addrNext;
    logic [IDX_W-1:0]  idxNext;

    // NOTE: every variable gets a default before the case logic so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        stateNext = state;
        tNext     = t;
        lineNext  = line;
        modeNext  = modeQ;
        baseNext  = baseQ;
        doneNext  = 1'b0;

        if (state == ST_IDLE) begin
            if (start) begin
                modeNext  = mode;
                baseNext  = src_base;
                lineNext  = '0;
                tNext     = '0;
                stateNext = ST_FILL;
            end
        end else if (t == T_LAST) begin
            tNext = '0;
            if (line == LINE_LAST) begin
                stateNext = ST_IDLE;
                lineNext  = '0;
                doneNext  = 1'b1;
            end else begin
                lineNext  = line + 1'b1;
                stateNext = ST_FILL;
            end
        end else begin
            tNext     = t + 1'b1;
            stateNext = phaseOf(tNext);
        end
    end

    // Outputs are registered, so they are derived from the next-cycle state.
    always_comb begin
        rdEnNext = (stateNext == ST_FILL) || (stateNext == ST_STREAM) || (stateNext == ST_TAIL);
        capNext  = (stateNext != ST_IDLE) && (tNext >= CAP_FIRST) && (tNext <= CAP_LAST);
        rNext    = lineT'(tNext - CAP_FIRST);
        case (stateNext)
            ST_STREAM: kNext = lineT'(tNext - STREAM_FIRST);
            ST_TAIL:   kNext = LINE_LAST;
            default:   kNext = '0;
        endcase
    end

    interp_addr_gen #(.W(ADDR_W)) rdAddrGen (
        .mode (modeNext),
        .base (baseNext),
        .line (lineNext),
        .pos  (kNext),
        .addr (addrNext)
    );

    interp_addr_gen #(.W(IDX_W)) capIdxGen (
        .mode (modeNext),
        .base ({IDX_W{1'b0}}),
        .line (lineNext),
        .pos  (rNext),
        .addr (idxNext)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            t         <= '0;
            line      <= '0;
            modeQ     <= MODE_ROW;
            baseQ     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            line_idx  <= '0;
        end else begin
            state     <= stateNext;
            t         <= tNext;
            line      <= lineNext;
            modeQ     <= modeNext;
            baseQ     <= baseNext;
            busy      <= (stateNext != ST_IDLE);
            done      <= doneNext;
            rd_en     <= rdEnNext;
            rd_addr   <= rdEnNext ? addrNext : '0;
            cap_valid <= capNext;
            cap_idx   <= capNext ? idxNext : '0;
            line_idx  <= IDX_W'(lineNext);
        end
    end

`ifdef INTERP_SEQ_PERF_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pass_cycles <= '0;
            pass_count  <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                pass_cycles <= '0;
            end else if (state != ST_IDLE) begin
                pass_cycles <= pass_cycles + 32'd1;
            end
            if (doneNext && pass_count != 16'hFFFF) begin
                pass_count <= pass_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_interp_line_sequencer.sv
// Self-checking bench: a cycle-index reference model of the padded line walk is
// compared against the sequencer every cycle, plus hand-computed anchor points.
module tb_interp_line_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [31:0] src_base;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        cap_valid;
    logic [7:0]  cap_idx;
    logic [7:0]  line_idx;
`ifdef INTERP_SEQ_PERF_EN
    logic [31:0] pass_cycles;
    logic [15:0] pass_count;
`endif

    interp_line_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .mode      (mode),
        .src_base  (src_base),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .cap_valid (cap_valid),
        .cap_idx   (cap_idx),
        .line_idx  (line_idx)
`ifdef INTERP_SEQ_PERF_EN
        ,
        .pass_cycles (pass_cycles),
        .pass_count  (pass_count)
`endif
    );

    always #5 clock = ~clock;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pass is 480 busy cycles indexed 0..479; cycle c is line
    // c/30, slot c%30. done shows in the first idle cycle afterwards.
    bit          mActive = 1'b0;
    bit          mDone   = 1'b0;
    int          mCyc    = 0;
    bit          mMode   = 1'b0;
    logic [31:0] mBase   = '0;
    int          mPassCycles = 0;
    int          mPassCount  = 0;

    always @(posedge clock) begin
        if (!reset_n) begin
            mActive = 1'b0;
            mDone   = 1'b0;
            mCyc    = 0;
            mMode   = 1'b0;
            mBase   = '0;
            mPassCycles = 0;
            mPassCount  = 0;
        end else begin
            mDone = 1'b0;
            if (mActive) begin
                mPassCycles++;
                if (mCyc == 479) begin
                    mActive = 1'b0;
                    mDone   = 1'b1;
                    if (mPassCount < 65535) mPassCount++;
                end else begin
                    mCyc++;
                end
            end else if (start) begin
                mActive = 1'b1;
                mCyc    = 0;
                mMode   = mode;
                mBase   = src_base;
                mPassCycles = 0;
            end
        end
    end

    bit          checkEn = 1'b0;
    int          eT, eLn, eK, eR;
    bit          expRdEn, expCap;
    logic [31:0] expAddr;
    logic [31:0] expIdx;
    logic [31:0] expLine;

    always @(negedge clock) begin
        if (checkEn) begin
            expRdEn = 1'b0;
            expCap  = 1'b0;
            expAddr = '0;
            expIdx  = '0;
            expLine = '0;
            if (mActive) begin
                eT  = mCyc % 30;
                eLn = mCyc / 30;
                eK  = (eT < 8) ? 0 : (eT < 24) ? eT - 8 : 15;
                eR  = eT - 14;
                expRdEn = (eT < 29);
                expCap  = (eT >= 14);
                expLine = eLn;
                if (expRdEn) expAddr = mMode ? mBase + eLn + eK * 16 : mBase + eLn * 16 + eK;
                if (expCap)  expIdx  = (mMode ? eLn + eR * 16 : eLn * 16 + eR) & 255;
            end
            check("busy", busy, mActive);
            check("done", done, mDone);
            check("rd_en", rd_en, expRdEn);
            check("rd_addr", rd_addr, expAddr);
            check("cap_valid", cap_valid, expCap);
            check("cap_idx", cap_idx, expIdx);
            check("line_idx", line_idx, expLine);
`ifdef INTERP_SEQ_PERF_EN
            check("pass_cycles", pass_cycles, mPassCycles);
            check("pass_count", pass_count, mPassCount);
`endif
        end
    end

    int cyc = 0;

    task automatic launch(input logic m, input logic [31:0] b);
        start    = 1'b1;
        mode     = m;
        src_base = b;
        @(negedge clock);
        start = 1'b0;
        cyc   = 0;
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic waitDone(input bit noise);
        while (!done && cyc < 600) begin
            start = noise && (cyc < 460) && ($urandom_range(0, 5) == 0);
            if (start) begin
                mode     = 1'($urandom_range(0, 1));
                src_base = $urandom;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        check("pass_len", cyc, 480);
    endtask

    function automatic logic [31:0] pickBase();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFF0;
            1:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    bit sawDone;

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        src_base = '0;
        repeat (2) @(negedge clock);
        checkEn = 1'b1;
        check("reset_busy", busy, 0);
        check("reset_rd_addr", rd_addr, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Row pass anchors, base 0x100.
        launch(1'b0, 32'h100);
        check("row_t0_addr", rd_addr, 32'h100);
        stepTo(7);  check("row_t7_addr", rd_addr, 32'h100);
        stepTo(8);  check("row_t8_addr", rd_addr, 32'h100);
        stepTo(14); check("row_t14_cap", cap_valid, 1); check("row_t14_idx", cap_idx, 0);
        stepTo(23); check("row_t23_addr", rd_addr, 32'h10F);
        stepTo(28); check("row_t28_addr", rd_addr, 32'h10F);
        stepTo(29); check("row_t29_rden", rd_en, 0); check("row_t29_idx", cap_idx, 15);
        waitDone(1'b0);

        // Column pass started in the done cycle; line 3 anchors.
        launch(1'b1, 32'h0);
        check("b2b_busy", busy, 1);
        stepTo(90);  check("col_l3_t0_addr", rd_addr, 3);
        stepTo(99);  check("col_l3_t9_addr", rd_addr, 19);
        stepTo(104); check("col_l3_t14_idx", cap_idx, 3);
        stepTo(105); check("col_l3_t15_idx", cap_idx, 19);
        stepTo(113); check("col_l3_t23_addr", rd_addr, 243);
        stepTo(119); check("col_l3_t29_idx", cap_idx, 243); check("col_l3_line", line_idx, 3);
        waitDone(1'b0);

        // Randomized passes with spurious start pulses while busy.
        repeat (3) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            launch(1'($urandom_range(0, 1)), pickBase());
            waitDone(1'b1);
        end

        // Reset at line 7, slot 20.
        launch(1'($urandom_range(0, 1)), pickBase());
        stepTo(230);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_cap_valid", cap_valid, 0);
        check("rst_line_idx", line_idx, 0);
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done) sawDone = 1'b1;
        end
        check("rst_no_done", sawDone, 0);

        // Two passes after reset, back to back.
        launch(1'($urandom_range(0, 1)), pickBase());
        waitDone(1'b0);
        launch(1'($urandom_range(0, 1)), pickBase());
        waitDone(1'b0);
`ifdef INTERP_SEQ_PERF_EN
        check("perf_cycles", pass_cycles, 480);
        check("perf_count", pass_count, 2);
`endif
        repeat (3) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", nChecks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/interp_line_sequencer.md
Name: interp_line_sequencer

Overview:
- Hardware sequencer that drives the 8-tap sub-pixel interpolator over a 16x16 pixel tile, one line (row or column) at a time.
- Issues read addresses to a synchronous tile RAM so the interpolator sees edge-padded lines: 8 copies of the first pixel, 16 line pixels, then 5 copies of the last pixel.
- Raises a capture strobe and destination index when the interpolator's a/b/c (or d/h/n) outputs are valid.
- Sits between the tile RAM and the interpolator; the result RAMs use cap_valid/cap_idx as their write enable and address.

Parameters:
- LINE_LEN, 16, pixels per line and lines per tile
- PRE_FILL, 8, leading pad cycles (repeat of first pixel)
- TAIL, 5, trailing pad cycles (repeat of last pixel)
- RD_LAT, 1, tile RAM read latency in cycles
- ADDR_W, 32, address width
- IDX_W, 8, result index width (log2 of LINE_LEN*LINE_LEN)

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  begin a tile pass; sampled only in IDLE
- mode  in  1  0 = row pass (stride 1), 1 = column pass (stride LINE_LEN); latched at start
- src_base  in  ADDR_W  tile base address; latched at start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final capture
- rd_en  out  1  tile RAM read enable
- rd_addr  out  ADDR_W  tile RAM read address
- cap_valid  out  1  interpolator outputs valid this cycle
- cap_idx  out  IDX_W  destination index of the current result
- line_idx  out  IDX_W  current line number, 0..LINE_LEN-1

Behaviour:
- Reset (synchronous, reset_n=0 at a posedge):
  - State goes to IDLE.
  - busy, done, rd_en, cap_valid are 0; rd_addr, cap_idx, line_idx are 0; latched mode and src_base are cleared.
  - Reset mid-pass aborts immediately. No done pulse. Next pass needs a fresh start.
- States: IDLE, FILL, STREAM, TAIL, DRAIN. A per-line cycle counter t=0..(PRE_FILL+LINE_LEN+TAIL+RD_LAT-1); default 0..29.
  - IDLE: start=1 latches mode and src_base, sets line=0, goes to FILL. start while not IDLE is ignored.
  - FILL, t=0..7: rd_en=1; rd_addr = address of pixel k=0.
  - STREAM, t=8..23: rd_en=1; rd_addr = address of pixel k=t-8.
  - TAIL, t=24..28: rd_en=1; rd_addr = address of pixel k=LINE_LEN-1.
  - DRAIN, t=29 (RD_LAT cycles): rd_en=0.
  - After DRAIN: if line<LINE_LEN-1, increment line and go to FILL with t=0 (lines are back to back, no bubble). Otherwise go to IDLE and pulse done for one cycle.
- Pixel address:
  - mode 0: src_base + line*LINE_LEN + k
  - mode 1: src_base + line + k*LINE_LEN
  - Unsigned; wraps modulo 2^ADDR_W.
- Capture: cap_valid=1 for t in [PRE_FILL+5+RD_LAT, PRE_FILL+20+RD_LAT], i.e. 14..29. That is exactly LINE_LEN strobes per line, with r=t-14.
- cap_idx:
  - mode 0: line*LINE_LEN + r
  - mode 1: line + r*LINE_LEN
  - Computed in IDX_W bits.
- Outputs are registered. rd_addr is 0 whenever rd_en=0; cap_idx is 0 whenever cap_valid=0.
- Pass length: LINE_LEN*30 = 480 cycles from the first FILL cycle to the done pulse, which falls in the cycle after the final DRAIN.
- done and a new start: done asserts in the first IDLE cycle. A start in that same cycle is accepted.
- The interpolator shifts every cycle and the sequencer never stalls; the `ready` input of the interpolator is tied high.

Optional Feature:
- Macro: INTERP_SEQ_PERF_EN.
- When defined:
  - Adds output ports pass_cycles[31:0] and pass_count[15:0].
  - pass_cycles counts cycles while busy. It is cleared when start is accepted and holds its value after done.
  - pass_count increments on each done pulse and saturates at 16'hFFFF.
  - Both reset to 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package interp_pkg holds:
  - the state enum (IDLE, FILL, STREAM, TAIL, DRAIN)
  - constants LINE_LEN, PRE_FILL, TAIL, RD_LAT
  - the mode encoding (MODE_ROW=0, MODE_COL=1)
- One sub-module, interp_addr_gen: combinational stride/offset calculator. It maps (mode, base, line, k) to an address and (mode, line, r) to a result index, and is instantiated twice.

Test Plan:
- Row pass, src_base=0x100: rd_addr sequence for line 0 is 0x100 ×8, 0x100..0x10F, 0x10F ×5. cap_idx goes 0..15 at t=14..29. done arrives 480 cycles after the first FILL cycle.
- Column pass, src_base=0: line 3 reads 3 ×8, then 3, 19, …, 243, then 243 ×5. cap_idx goes 3, 19, …, 243.
- Golden-model check: feed the tile 0,8,17,…,255 through the RAM, sequencer and interpolator, and compare the captured aValue[37:6], bValue[37:6], cValue[37:6] per index against the software model.
- start pulsed while busy: the request is ignored and the address stream is unchanged. start in the done cycle: the next pass begins with no idle gap.
- reset_n=0 at line 7, t=20: all outputs read 0 in the next cycle and no done pulse occurs. A subsequent start runs a full 480-cycle pass.
- With INTERP_SEQ_PERF_EN: after two passes, pass_cycles=480 and pass_count=2.
